// File: rtl/alu_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler_if
// Request/response bundle between the command sources and alu_rr_scheduler.
//   req_valid/req_ready  per-requester request handshake
//   req_op/req_a/req_b   packed per-requester ALU control and operands
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_result/rsp_flags shared response payload {N, V, C, Z}
// master: command-source side, slave: scheduler side.
// ---------------------------------------------------------------------------
interface alu_rr_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned FLAG_W = 4;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [OP_W*NREQ-1:0]   req_op;
  logic [DATA_W*NREQ-1:0] req_a;
  logic [DATA_W*NREQ-1:0] req_b;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]      rsp_result;
  logic [FLAG_W-1:0]      rsp_flags;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one combinational ALU among NREQ requesters. One operation is in
// flight at a time: IDLE grants a requester round-robin and latches its
// operands, EXEC captures the ALU result/flags, RESP returns them to the
// granted requester until it accepts.
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   bus (slave)              request/response handshakes and payloads
//   alu_a, alu_b, alu_ctrl   registered operands/control to the ALU
//   alu_result, alu_*        ALU result and flags
//   busy                     high whenever the FSM is not IDLE
//   done_cnt                 wrapping count of completed responses
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  alu_rr_scheduler_if.slave bus,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [4:0]        alu_ctrl,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              alu_neg,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [NREQ-1:0]     req_ready_c;

  // Index k positions after base, modulo NREQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int unsigned    k);
    return IDX_W'((32'(base) + k) % NREQ);
  endfunction

  // Round-robin pick: scan from last_grant+1, last_grant itself is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!win_found && bus.req_valid[rr_idx(last_grant_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(last_grant_q, k);
      end
    end
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    flags_d      = flags_q;
    cnt_d        = cnt_q;
    req_ready_c  = '0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready_c  = NREQ'(1) << win_idx;
          op_d         = bus.req_op[OP_W*32'(win_idx) +: OP_W];
          a_d          = bus.req_a[DATA_W*32'(win_idx) +: DATA_W];
          b_d          = bus.req_b[DATA_W*32'(win_idx) +: DATA_W];
          owner_d      = win_idx;
          last_grant_d = win_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        flags_d = {alu_neg, alu_ovf, alu_carry, alu_zero};
        state_d = RESP;
      end
      RESP: begin
        // Only the owner's rsp_ready can complete the handshake.
        if (bus.rsp_ready[owner_q]) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      owner_q      <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
      cnt_q        <= cnt_d;
    end
  end

  // Output decode; req_ready is the only combinational-from-input output.
  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = (state_q == RESP) ? (NREQ'(1) << owner_q) : '0;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flags_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_ctrl       = op_q;
  assign busy           = (state_q != IDLE);
  assign done_cnt       = cnt_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
// Directed bench for alu_rr_scheduler with a small ALU model on the ALU side.
// ALU codes used here: 0 AND, 1 OR, 2 XOR, 5 ADDS, 6 SUBS, 8 MULTS.
// Flags are {N, V, C, Z}; SUBS carry is "no borrow".
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned CNT_W = 4;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [31:0]       alu_a, alu_b, alu_result;
  logic [4:0]        alu_ctrl;
  logic              alu_zero, alu_carry, alu_ovf, alu_neg;
  logic              busy;
  logic [CNT_W-1:0]  done_cnt;

  int unsigned       n_vec = 0;
  int unsigned       n_err = 0;
  logic [CNT_W-1:0]  exp_cnt;

  alu_rr_scheduler_if #(.NREQ(NREQ)) bus ();

  alu_rr_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .alu_neg    (alu_neg),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  always #5 PCLK = ~PCLK;

  // Reference ALU driven by the scheduler's operand registers.
  logic [32:0] alu_s;
  logic [63:0] alu_p;
  always_comb begin
    alu_s      = '0;
    alu_p      = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_ctrl)
      5'd0: alu_result = alu_a & alu_b;
      5'd1: alu_result = alu_a | alu_b;
      5'd2: alu_result = alu_a ^ alu_b;
      5'd5: begin
        alu_s      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_s[31:0];
        alu_carry  = alu_s[32];
        alu_ovf    = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      5'd6: begin
        alu_s      = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = alu_s[31:0];
        alu_carry  = ~alu_s[32];
        alu_ovf    = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      5'd8: begin
        alu_p      = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
        alu_result = alu_p[31:0];
        alu_ovf    = (alu_p[63:32] != {32{alu_p[31]}});
      end
      default: alu_result = '0;
    endcase
    alu_neg  = alu_result[31];
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int r);
    return NREQ'(32'd1 << r);
  endfunction

  task automatic idle_bus();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    idle_bus();
    exp_cnt = '0;
    cyc();
    cyc();
    PRESETn = 1'b1;
    #1;
  endtask

  task automatic set_req(input int r, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_op[5*r +: 5] = op;
    bus.req_a[32*r +: 32] = a;
    bus.req_b[32*r +: 32] = b;
  endtask

  // Single requester, full transaction with cycle-exact checks.
  task automatic do_op(input string tag, input int r, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] flg);
    set_req(r, op, a, b);
    bus.req_valid = oh(r);
    #1;
    check({tag, " ready"}, 32'(bus.req_ready), 32'(oh(r)));
    cyc();
    bus.req_valid = '0;
    #1;
    check({tag, " exec rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " exec ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, " exec busy"}, 32'(busy), 32'd1);
    check({tag, " alu_a"}, alu_a, a);
    check({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(op));
    cyc();
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(oh(r)));
    check({tag, " result"}, bus.rsp_result, res);
    check({tag, " flags"}, 32'(bus.rsp_flags), 32'(flg));
    bus.rsp_ready = oh(r);
    cyc();
    exp_cnt = exp_cnt + CNT_W'(1);
    bus.rsp_ready = '0;
    #1;
    check({tag, " done_cnt"}, 32'(done_cnt), 32'(exp_cnt));
    check({tag, " post rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " post busy"}, 32'(busy), 32'd0);
  endtask

  logic [31:0] s_res [5];
  logic [3:0]  s_flg [5];

  initial begin
    // Reset values and the first ADDS transaction.
    PRESETn = 1'b0;
    idle_bus();
    exp_cnt = '0;
    #2;
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done_cnt", 32'(done_cnt), 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst rsp_result", bus.rsp_result, 32'd0);
    check("rst rsp_flags", 32'(bus.rsp_flags), 32'd0);
    cyc();
    PRESETn = 1'b1;
    #1;
    do_op("adds", 0, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0011);

    // All requesters valid, rsp_ready high: grants 0,1,2,3,0 every 3 cycles.
    do_reset();
    set_req(0, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    set_req(1, 5'd1, 32'h0000_00F0, 32'h0000_000F);
    set_req(2, 5'd2, 32'h1234_5678, 32'h1234_5678);
    set_req(3, 5'd6, 32'd5,         32'd7);
    s_res[0] = 32'hF000_F000; s_flg[0] = 4'b1000;
    s_res[1] = 32'h0000_00FF; s_flg[1] = 4'b0000;
    s_res[2] = 32'h0000_0000; s_flg[2] = 4'b0001;
    s_res[3] = 32'hFFFF_FFFE; s_flg[3] = 4'b1000;
    s_res[4] = 32'hF000_F000; s_flg[4] = 4'b1000;
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rr%0d grant", g), 32'(bus.req_ready), 32'(oh(g % 4)));
      cyc();
      check($sformatf("rr%0d exec ready", g), 32'(bus.req_ready), 32'd0);
      check($sformatf("rr%0d exec rsp_valid", g), 32'(bus.rsp_valid), 32'd0);
      cyc();
      check($sformatf("rr%0d resp ready", g), 32'(bus.req_ready), 32'd0);
      check($sformatf("rr%0d rsp_valid", g), 32'(bus.rsp_valid), 32'(oh(g % 4)));
      check($sformatf("rr%0d result", g), bus.rsp_result, s_res[g]);
      check($sformatf("rr%0d flags", g), 32'(bus.rsp_flags), 32'(s_flg[g]));
      cyc();
      exp_cnt = exp_cnt + CNT_W'(1);
      check($sformatf("rr%0d done_cnt", g), 32'(done_cnt), 32'(exp_cnt));
    end
    idle_bus();
    #1;

    // Requester 2 stalls in RESP; requester 1's rsp_ready must be ignored.
    set_req(2, 5'd2, 32'hFFFF_0000, 32'h0F0F_0F0F);
    bus.req_valid = oh(2);
    #1;
    check("stall grant", 32'(bus.req_ready), 32'(oh(2)));
    cyc();
    bus.req_valid = '0;
    cyc();
    bus.req_valid = 4'b1011;
    bus.rsp_ready = oh(1);
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("stall%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(oh(2)));
      check($sformatf("stall%0d result", i), bus.rsp_result, 32'hF0F0_0F0F);
      check($sformatf("stall%0d flags", i), 32'(bus.rsp_flags), 32'(4'b1000));
      check($sformatf("stall%0d req_ready", i), 32'(bus.req_ready), 32'd0);
      check($sformatf("stall%0d done_cnt", i), 32'(done_cnt), 32'(exp_cnt));
      cyc();
    end
    bus.req_valid = '0;
    bus.rsp_ready = oh(2);
    cyc();
    exp_cnt = exp_cnt + CNT_W'(1);
    bus.rsp_ready = '0;
    #1;
    check("stall done_cnt", 32'(done_cnt), 32'(exp_cnt));
    check("stall release", 32'(bus.rsp_valid), 32'd0);

    // Signed overflow corner cases.
    do_op("subs ovf", 3, 5'd6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0110);
    do_op("mults ovf", 1, 5'd8, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0101);

    // Reset mid-EXEC discards the op; requester 0 regains priority.
    set_req(2, 5'd2, 32'hAAAA_5555, 32'd1);
    bus.req_valid = oh(2);
    #1;
    check("abort grant", 32'(bus.req_ready), 32'(oh(2)));
    cyc();
    bus.req_valid = '0;
    #1;
    check("abort busy", 32'(busy), 32'd1);
    PRESETn = 1'b0;
    #1;
    exp_cnt = '0;
    check("abort busy async", 32'(busy), 32'd0);
    check("abort alu_a async", alu_a, 32'd0);
    check("abort alu_ctrl async", 32'(alu_ctrl), 32'd0);
    check("abort done_cnt async", 32'(done_cnt), 32'd0);
    check("abort rsp_valid async", 32'(bus.rsp_valid), 32'd0);
    cyc();
    PRESETn = 1'b1;
    cyc();
    cyc();
    check("abort no rsp", 32'(bus.rsp_valid), 32'd0);
    check("abort idle", 32'(busy), 32'd0);
    set_req(0, 5'd5, 32'd1, 32'd2);
    set_req(1, 5'd0, 32'd3, 32'd3);
    set_req(2, 5'd1, 32'd4, 32'd4);
    set_req(3, 5'd2, 32'd5, 32'd5);
    bus.req_valid = '1;
    #1;
    check("abort prio0", 32'(bus.req_ready), 32'(oh(0)));
    cyc();
    bus.req_valid = '0;
    cyc();
    check("abort rsp0 valid", 32'(bus.rsp_valid), 32'(oh(0)));
    check("abort rsp0 result", bus.rsp_result, 32'd3);
    bus.rsp_ready = oh(0);
    cyc();
    exp_cnt = exp_cnt + CNT_W'(1);
    bus.rsp_ready = '0;
    #1;
    check("abort rsp0 done_cnt", 32'(done_cnt), 32'(exp_cnt));

    // Counter wrap: 17 completions on a 4-bit counter leaves 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      do_op($sformatf("wrap%0d", i), i % 4, 5'd5, 32'(i), 32'd1, 32'(i + 1), 4'b0000);
    end
    check("wrap done_cnt", 32'(done_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares one combinational ALU (32-bit A/B, 5-bit ALUControl, Result plus Zero/Carry/Overflow/Negative flags) among NREQ requesters. The block accepts one operation at a time over a valid/ready request handshake and drives the ALU from registered operands. It captures the result and flags, then returns them to the granted requester over a valid/ready response handshake. It sits between the bus-side command sources and the ALU instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- CNT_W, 16, width of the completed-operation counter
- PCLK  in  1  clock; all state updates on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accept (one-hot or zero)
- req_op  in  5*NREQ  ALUControl code, requester i at [5i+4:5i]
- req_a  in  32*NREQ  operand A, requester i at [32i+31:32i]
- req_b  in  32*NREQ  operand B, same packing
- rsp_valid  out  NREQ  per-requester response valid (one-hot or zero)
- rsp_ready  in  NREQ  per-requester response accept
- rsp_result  out  32  shared result bus, meaningful only while rsp_valid != 0
- rsp_flags  out  4  {Negative, Overflow, Carry, Zero}, same validity
- alu_a, alu_b  out  32  to ALU operands
- alu_ctrl  out  5  to ALU ALUControl
- alu_result  in  32  from ALU Result
- alu_zero, alu_carry, alu_ovf, alu_neg  in  1  from ALU flags
- busy  out  1  high in any state except IDLE
- done_cnt  out  CNT_W  count of completed response handshakes

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset enters IDLE.
- **IDLE:** if req_valid != 0, select the winner by round-robin. Search starts at last_grant+1 (mod NREQ) and takes the first set bit.
  - Assert req_ready[winner] combinationally in this cycle only.
  - On the edge, latch op/a/b of the winner into operand registers, record owner = winner and last_grant = winner, then go to EXEC.
- **EXEC:** alu_a/alu_b/alu_ctrl are driven from the operand registers (they hold these values in every state). On the edge, capture alu_result and the flags into result registers, then go to RESP.
- **RESP:** rsp_valid[owner] = 1. rsp_result/rsp_flags come from the result registers and stay stable until accepted.
  - When rsp_ready[owner] = 1, the handshake completes: done_cnt increments (wraps at 2^CNT_W-1 → 0) and the FSM goes to IDLE.
  - rsp_ready of non-owners is ignored.
- req_ready is 0 in EXEC and RESP; requests arriving then wait. A requester must hold req_valid and its fields stable until it sees req_ready.
- A requester that just completed re-enters arbitration with lowest priority (pointer already moved past it).
- All 32 ALUControl codes are forwarded unchanged; the scheduler does not interpret op codes.

## Timing
- Reset values:
  - state = IDLE
  - last_grant = NREQ-1, so requester 0 wins first
  - operand registers = 0, so alu_a = alu_b = 0 and alu_ctrl = 0
  - result and flag registers = 0
  - req_ready = 0, rsp_valid = 0, busy = 0, done_cnt = 0
- Latency: a request accepted in cycle T gets rsp_valid high in cycle T+2. With rsp_ready held high, the next request can be accepted at T+3. Peak throughput is 1 op per 3 cycles.
- Simultaneous requests: only one is granted per IDLE cycle. With all NREQ held valid, grant order is 0,1,2,…,NREQ-1,0,…
- A request dropped before acceptance is never granted; no state is kept for it.
- A PRESETn assertion mid-EXEC or mid-RESP discards the operation immediately. Outputs go to reset values asynchronously, and the pending response is lost.
- A response that is never accepted stalls the block in RESP indefinitely, by design.

## Test plan
- Reset release, requester 0 sends op=5'b00101, A=32'hFFFF_FFFF, B=1 → req_ready[0] in cycle 0; rsp_valid[0] at cycle 2 with result 0, flags {N=0,V=0,C=1,Z=1}; done_cnt=1 after handshake.
- All 4 requesters valid continuously with distinct ops (AND, OR, XOR, SUBS), rsp_ready tied high → grants in order 0,1,2,3,0; each response carries its own requester's result; accepts spaced exactly 3 cycles apart.
- Requester 2 in RESP with rsp_ready[2] held low for 10 cycles while requester 1 asserts rsp_ready → rsp_valid[2], result and flags stay stable; req_ready stays 0; no other grant occurs.
- SUBS A=32'h8000_0000, B=1 → result 32'h7FFF_FFFF, Overflow=1, Negative=0; MULTS A=32'h0001_0000, B=32'h0001_0000 → result 0, Zero=1, Overflow=1.
- PRESETn pulsed low during EXEC → all outputs reset asynchronously; no response is issued for that op; after release, requester 0 has priority again.
- CNT_W=4, complete 17 operations → done_cnt reads 1, confirming wrap.
